// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// fills the IF/ID register with a clean valid/bubble stream.
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_data_i,
  output logic              if_id_valid_o,
  output logic [31:0]       if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic              misalign_o,
  output logic              halted_o
);

  localparam logic [31:0]       EBREAK_INSTR = 32'h0010_0073;
  localparam logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;
  logic              misalign_q, misalign_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] pc_inc;

  // Redirect target forced word-aligned; sequential PC wraps mod 2^ADDR_W.
  assign redirect_tgt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign pc_inc       = pc_q + PC_STEP;

  // Next-state and IF/ID update; redirect beats flush beats stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    misalign_d = 1'b0;
    halted_d   = halted_q;

    unique case (state_q)
      ST_BOOT: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_i) begin
          pc_d       = redirect_tgt;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          misalign_d = |redirect_pc_i[1:0];
        end else if (flush_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (!stall_i) begin
          valid_d  = 1'b1;
          instr_d  = imem_data_i;
          if_pc_d  = pc_q;
          if_pc4_d = pc_inc;
          pc_d     = pc_inc;
          if (imem_data_i == EBREAK_INSTR) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (redirect_i) begin
          pc_d       = redirect_tgt;
          misalign_d = |redirect_pc_i[1:0];
          state_d    = ST_RUN;
          halted_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, PC and IF/ID registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      if_pc_q    <= '0;
      if_pc4_q   <= '0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      misalign_q <= misalign_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr_o   = {pc_q[ADDR_W-1:2], 2'b00};
  assign if_id_valid_o = valid_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = if_pc_q;
  assign if_id_pc4_o   = if_pc4_q;
  assign misalign_o    = misalign_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic              clk;
  logic              rst;
  logic              stall_i, flush_i, redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_i;
  logic              if_id_valid_o;
  logic [31:0]       if_id_instr_o;
  logic [ADDR_W-1:0] if_id_pc_o, if_id_pc4_o;
  logic              misalign_o, halted_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Instruction memory: 64 programmable words at 0x00..0xFC, a fixed
  // address-derived pattern elsewhere (low bits 00, so never an EBREAK).
  logic [31:0] mem [0:63];

  fetch_stage #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .if_id_valid_o(if_id_valid_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_pc4_o  (if_id_pc4_o),
    .misalign_o   (misalign_o),
    .halted_o     (halted_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    if (imem_addr_o < 32'h100) imem_data_i = mem[imem_addr_o[7:2]];
    else                       imem_data_i = imem_addr_o ^ 32'h5A5A_0000;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    if (al < 32'h100) return mem[al[7:2]];
    return al ^ 32'h5A5A_0000;
  endfunction

  // Behavioural model of the stage's architectural state.
  logic        m_boot, m_halt, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
    m_pc = 32'h0; m_instr = NOP; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
  endtask

  function automatic logic [130:0] model_vec();
    return {m_valid, m_instr, m_ifpc, m_ifpc4, m_pc, m_mis, m_halt};
  endfunction

  function automatic logic [130:0] dut_vec();
    return {if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o,
            imem_addr_o, misalign_o, halted_o};
  endfunction

  // Drive one cycle's controls, advance the model across the edge, settle.
  task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
    logic [31:0] word;
    stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = t;
    word = mem_word(m_pc);
    @(posedge clk);
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b0; m_instr = NOP;
    end else if (r) begin
      m_pc = t & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = NOP;
      m_mis = (t[1:0] != 2'b00); m_halt = 1'b0;
    end else if (m_halt || f) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (!s) begin
      m_valid = 1'b1; m_instr = word; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      if (word == EBREAK) m_halt = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    model_reset();
    #12;
    n_checks++;
    if (dut_vec() !== {1'b0, NOP, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_values: got %h expected %h", dut_vec(),
               {1'b0, NOP, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0050_0093; exp_w[1] = 32'h00A0_0113; exp_w[2] = 32'h0020_81B3;
    #2 rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_valid_o, if_id_instr_o, imem_addr_o} !== {1'b0, NOP, 32'h0})
      $display("FAIL boot_bubble: got %h expected %h",
               {if_id_valid_o, if_id_instr_o, imem_addr_o}, {1'b0, NOP, 32'h0});
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if ({if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o} !==
          {1'b1, exp_w[i], 32'(i * 4), 32'(i * 4 + 4)})
        $display("FAIL seq_fetch_%0d: got %h expected %h", i,
                 {if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o},
                 {1'b1, exp_w[i], 32'(i * 4), 32'(i * 4 + 4)});
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if ({if_id_valid_o, if_id_pc_o, imem_addr_o} !== {1'b1, 32'h4, 32'h8})
        $display("FAIL stall_hold_%0d: got %h expected %h", i,
                 {if_id_valid_o, if_id_pc_o, imem_addr_o}, {1'b1, 32'h4, 32'h8});
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_instr_o, if_id_pc_o, if_id_pc4_o} !== {32'h0020_81B3, 32'h8, 32'hC})
      $display("FAIL stall_resume: got %h expected %h",
               {if_id_instr_o, if_id_pc_o, if_id_pc4_o}, {32'h0020_81B3, 32'h8, 32'hC});
    else n_pass++;
    n_checks++;
    if (dut_vec() !== model_vec())
      $display("FAIL stall_model: got %h expected %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_redirect_priority();
    step(1'b1, 1'b1, 1'b1, 32'h40);
    n_checks++;
    if ({imem_addr_o, if_id_valid_o, if_id_instr_o} !== {32'h40, 1'b0, NOP})
      $display("FAIL redirect_prio: got %h expected %h",
               {imem_addr_o, if_id_valid_o, if_id_instr_o}, {32'h40, 1'b0, NOP});
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_valid_o, if_id_pc_o} !== {1'b1, 32'h40})
      $display("FAIL redirect_target: got %h expected %h",
               {if_id_valid_o, if_id_pc_o}, {1'b1, 32'h40});
    else n_pass++;
  endtask

  task automatic test_misalign_flush();
    step(1'b0, 1'b0, 1'b1, 32'h42);
    n_checks++;
    if ({imem_addr_o, misalign_o} !== {32'h40, 1'b1})
      $display("FAIL misalign_pulse: got %h expected %h", {imem_addr_o, misalign_o}, {32'h40, 1'b1});
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (misalign_o !== 1'b0)
      $display("FAIL misalign_clear: got %b expected 0", misalign_o);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_valid_o, if_id_instr_o, imem_addr_o} !== {1'b0, NOP, 32'h44})
      $display("FAIL flush_bubble: got %h expected %h",
               {if_id_valid_o, if_id_instr_o, imem_addr_o}, {1'b0, NOP, 32'h44});
    else n_pass++;
  endtask

  task automatic test_halt();
    step(1'b0, 1'b0, 1'b1, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc_o, halted_o, imem_addr_o} !==
        {1'b1, EBREAK, 32'h10, 1'b1, 32'h14})
      $display("FAIL ebreak_capture: got %h expected %h",
               {if_id_valid_o, if_id_instr_o, if_id_pc_o, halted_o, imem_addr_o},
               {1'b1, EBREAK, 32'h10, 1'b1, 32'h14});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      n_checks++;
      if ({if_id_valid_o, if_id_instr_o, halted_o, imem_addr_o} !== {1'b0, NOP, 1'b1, 32'h14})
        $display("FAIL halt_hold_%0d: got %h expected %h", i,
                 {if_id_valid_o, if_id_instr_o, halted_o, imem_addr_o}, {1'b0, NOP, 1'b1, 32'h14});
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    n_checks++;
    if ({halted_o, imem_addr_o} !== {1'b0, 32'h0})
      $display("FAIL halt_exit: got %h expected %h", {halted_o, imem_addr_o}, {1'b0, 32'h0});
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_valid_o, if_id_instr_o, if_id_pc_o} !== {1'b1, 32'h0050_0093, 32'h0})
      $display("FAIL halt_resume: got %h expected %h",
               {if_id_valid_o, if_id_instr_o, if_id_pc_o}, {1'b1, 32'h0050_0093, 32'h0});
    else n_pass++;
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({if_id_pc_o, if_id_pc4_o, imem_addr_o} !== {32'hFFFF_FFFC, 32'h0, 32'h0})
      $display("FAIL pc_wrap: got %h expected %h",
               {if_id_pc_o, if_id_pc4_o, imem_addr_o}, {32'hFFFF_FFFC, 32'h0, 32'h0});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 9) == 0), t);
      n_checks++;
      if (dut_vec() !== model_vec())
        $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== {1'b0, NOP, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0})
      $display("FAIL async_reset: got %h expected %h", dut_vec(),
               {1'b0, NOP, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (dut_vec() !== model_vec())
        $display("FAIL post_reset_%0d: got %h expected %h", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i * 4) ^ 32'h5A5A_0000;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h00A0_0113;
    mem[2]  = 32'h0020_81B3;
    mem[4]  = EBREAK;
    mem[20] = EBREAK;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect_priority();
    test_misalign_flush();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
